iq_issue_scheduler: RTL and testbench

IQ_ISSUE_SCHEDULER -- requirements
Module: iq_issue_scheduler

---
 rtl/drac_pkg.sv | 18 +
 rtl/iq_hazard_check.sv | 31 +++
 rtl/iq_issue_scheduler.sv | 95 +++++++++
 tb/tb_iq_issue_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// rtl/drac_pkg.sv - shared issue-stage types and constants
package drac_pkg;

  localparam int unsigned ISSUE_WIDTH = 2;

  typedef enum logic [1:0] {
    UNIT_ALU    = 2'd0,
    UNIT_BR     = 2'd1,
    UNIT_MEM    = 2'd2,
    UNIT_MULDIV = 2'd3
  } issue_unit_t;

  typedef enum logic {
    SCHED_RUN         = 1'b0,
    SCHED_SERIAL_WAIT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/iq_hazard_check.sv
// rtl/iq_hazard_check.sv - pairwise RAW/WAW/structural check between slot 0 and slot 1
import drac_pkg::*;

module iq_hazard_check (
  input  logic        rd0_we,
  input  logic [4:0]  rd0,
  input  issue_unit_t unit0,
  input  logic        rd1_we,
  input  logic [4:0]  rd1,
  input  logic        rs1_1_use,
  input  logic [4:0]  rs1_1,
  input  logic        rs2_1_use,
  input  logic [4:0]  rs2_1,
  input  issue_unit_t unit1,
  output logic        hazard
);

  logic raw;
  logic waw;
  logic structural;

  // x0 never carries a dependency, so a zero rd cannot cause RAW or WAW
  assign raw = rd0_we && (rd0 != 5'd0) &&
               ((rs1_1_use && (rs1_1 == rd0)) || (rs2_1_use && (rs2_1 == rd0)));
  assign waw = rd0_we && rd1_we && (rd0 != 5'd0) && (rd0 == rd1);
  assign structural = ((unit0 == UNIT_MEM) && (unit1 == UNIT_MEM)) ||
                      ((unit0 == UNIT_MULDIV) && (unit1 == UNIT_MULDIV));

  assign hazard = raw || waw || structural;

endmodule

// File: rtl/iq_issue_scheduler.sv
// rtl/iq_issue_scheduler.sv - dual-issue in-order scheduler with serialization wait and perf counters
import drac_pkg::*;

module iq_issue_scheduler #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              flush_i,
  input  logic        [ISSUE_WIDTH-1:0]      head_valid_i,
  input  logic        [ISSUE_WIDTH-1:0][4:0] head_rd_i,
  input  logic        [ISSUE_WIDTH-1:0][4:0] head_rs1_i,
  input  logic        [ISSUE_WIDTH-1:0][4:0] head_rs2_i,
  input  logic        [ISSUE_WIDTH-1:0]      head_rd_we_i,
  input  logic        [ISSUE_WIDTH-1:0]      head_rs1_use_i,
  input  logic        [ISSUE_WIDTH-1:0]      head_rs2_use_i,
  input  issue_unit_t [ISSUE_WIDTH-1:0]      head_unit_i,
  input  logic        [ISSUE_WIDTH-1:0]      head_serial_i,
  input  logic        [ISSUE_WIDTH-1:0]      ready_i,
  input  logic                              drain_done_i,
  input  logic                              clear_cnt_i,
  output logic        [ISSUE_WIDTH-1:0]      read_head_o,
  output logic        [ISSUE_WIDTH-1:0]      issue_valid_o,
  output logic                              busy_o,
  output logic        [CNT_W-1:0]            cnt_dual_o,
  output logic        [CNT_W-1:0]            cnt_single_o,
  output logic        [CNT_W-1:0]            cnt_stall_o
);

  sched_state_t             state_q, state_d;
  logic [ISSUE_WIDTH-1:0]   read_head;
  logic                     hazard;
  logic                     issue_ok;
  logic                     unused_slot0_srcs;

  // Slot 0 sources only matter to older, already-issued instructions
  assign unused_slot0_srcs = ^{head_rs1_i[0], head_rs2_i[0], head_rs1_use_i[0], head_rs2_use_i[0]};

  iq_hazard_check u_hazard (
    .rd0_we    (head_rd_we_i[0]),
    .rd0       (head_rd_i[0]),
    .unit0     (head_unit_i[0]),
    .rd1_we    (head_rd_we_i[1]),
    .rd1       (head_rd_i[1]),
    .rs1_1_use (head_rs1_use_i[1]),
    .rs1_1     (head_rs1_i[1]),
    .rs2_1_use (head_rs2_use_i[1]),
    .rs2_1     (head_rs2_i[1]),
    .unit1     (head_unit_i[1]),
    .hazard    (hazard)
  );

  assign issue_ok = rstn_i && !flush_i && (state_q == SCHED_RUN);

  always_comb begin
    read_head    = '0;
    state_d      = state_q;
    read_head[0] = issue_ok && head_valid_i[0] && ready_i[0];
    read_head[1] = read_head[0] && head_valid_i[1] && ready_i[1] &&
                   !head_serial_i[0] && !head_serial_i[1] && !hazard;
    case (state_q)
      SCHED_RUN:         if (read_head[0] && head_serial_i[0]) state_d = SCHED_SERIAL_WAIT;
      SCHED_SERIAL_WAIT: if (drain_done_i) state_d = SCHED_RUN;
      default:           state_d = SCHED_RUN;
    endcase
    if (flush_i) state_d = SCHED_RUN;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= SCHED_RUN;
      cnt_dual_o   <= '0;
      cnt_single_o <= '0;
      cnt_stall_o  <= '0;
    end else begin
      state_q <= state_d;
      if (clear_cnt_i) begin
        cnt_dual_o   <= '0;
        cnt_single_o <= '0;
        cnt_stall_o  <= '0;
      end else if (read_head == 2'b11) begin
        cnt_dual_o <= cnt_dual_o + 1'b1;
      end else if (read_head != 2'b00) begin
        cnt_single_o <= cnt_single_o + 1'b1;
      end else if (head_valid_i[0] && !flush_i) begin
        cnt_stall_o <= cnt_stall_o + 1'b1;
      end
    end
  end

  assign read_head_o   = read_head;
  assign issue_valid_o = read_head;
  assign busy_o        = (state_q == SCHED_SERIAL_WAIT);

endmodule

// File: tb/tb_iq_issue_scheduler.sv
// tb/tb_iq_issue_scheduler.sv - directed table-driven bench for iq_issue_scheduler
import drac_pkg::*;

module tb_iq_issue_scheduler;

  localparam int unsigned CW = 4;

  typedef struct {
    logic        v;
    issue_unit_t unit;
    logic [4:0]  rd;
    logic        we;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic        serial;
  } slot_t;

  typedef struct {
    slot_t      s0;
    slot_t      s1;
    logic [1:0] ready;
    logic [1:0] exp_rh;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rstn, flush, drain_done, clear_cnt;
  logic        [1:0]      head_valid, head_rd_we, head_rs1_use, head_rs2_use, head_serial, ready;
  logic        [1:0][4:0] head_rd, head_rs1, head_rs2;
  issue_unit_t [1:0]      head_unit;
  logic [1:0]    read_head, issue_valid;
  logic          busy;
  logic [CW-1:0] cnt_dual, cnt_single, cnt_stall;

  int total = 0;
  int bad = 0;
  logic [CW-1:0] e_dual = '0, e_single = '0, e_stall = '0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  iq_issue_scheduler #(.CNT_W(CW)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .head_valid_i(head_valid), .head_rd_i(head_rd), .head_rs1_i(head_rs1), .head_rs2_i(head_rs2),
    .head_rd_we_i(head_rd_we), .head_rs1_use_i(head_rs1_use), .head_rs2_use_i(head_rs2_use),
    .head_unit_i(head_unit), .head_serial_i(head_serial), .ready_i(ready),
    .drain_done_i(drain_done), .clear_cnt_i(clear_cnt),
    .read_head_o(read_head), .issue_valid_o(issue_valid), .busy_o(busy),
    .cnt_dual_o(cnt_dual), .cnt_single_o(cnt_single), .cnt_stall_o(cnt_stall)
  );

  function automatic slot_t mk(logic v, issue_unit_t unit, logic [4:0] rd, logic we,
                               logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2, logic serial);
    slot_t s;
    s.v = v; s.unit = unit; s.rd = rd; s.we = we;
    s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2; s.serial = serial;
    return s;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(slot_t s0, slot_t s1, logic [1:0] rdy, logic [1:0] exp_rh, string name);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.ready = rdy; v.exp_rh = exp_rh; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic drive(slot_t s0, slot_t s1, logic [1:0] rdy);
    head_valid   = {s1.v, s0.v};
    head_unit[0] = s0.unit;    head_unit[1] = s1.unit;
    head_rd[0]   = s0.rd;      head_rd[1]   = s1.rd;
    head_rs1[0]  = s0.rs1;     head_rs1[1]  = s1.rs1;
    head_rs2[0]  = s0.rs2;     head_rs2[1]  = s1.rs2;
    head_rd_we   = {s1.we, s0.we};
    head_rs1_use = {s1.u1, s0.u1};
    head_rs2_use = {s1.u2, s0.u2};
    head_serial  = {s1.serial, s0.serial};
    ready        = rdy;
  endtask

  // One cycle: drive, check combinational pop, clock, check state and counters.
  task automatic step(slot_t s0, slot_t s1, logic [1:0] rdy, logic drn, logic fl, logic clr,
                      logic [1:0] exp_rh, logic exp_busy, string name);
    drive(s0, s1, rdy);
    drain_done = drn; flush = fl; clear_cnt = clr;
    #1;
    chk({name, " read_head"}, 32'(read_head), 32'(exp_rh));
    chk({name, " issue_valid"}, 32'(issue_valid), 32'(exp_rh));
    if (clr) begin
      e_dual = '0; e_single = '0; e_stall = '0;
    end else if (exp_rh == 2'b11) e_dual++;
    else if (exp_rh != 2'b00) e_single++;
    else if (s0.v && !fl) e_stall++;
    @(posedge clk); #1;
    drain_done = 1'b0; flush = 1'b0; clear_cnt = 1'b0;
    chk({name, " busy"}, 32'(busy), 32'(exp_busy));
    chk({name, " cnt_dual"}, 32'(cnt_dual), 32'(e_dual));
    chk({name, " cnt_single"}, 32'(cnt_single), 32'(e_single));
    chk({name, " cnt_stall"}, 32'(cnt_stall), 32'(e_stall));
  endtask

  initial begin
    slot_t alu_a, alu_b, raw1, raw2, mem, mdv, csr, nil, waw0, waw1;
    alu_a = mk(1, UNIT_ALU, 5'd5, 1, 5'd1, 1, 5'd2, 1, 0);
    alu_b = mk(1, UNIT_ALU, 5'd6, 1, 5'd3, 1, 5'd4, 1, 0);
    raw1  = mk(1, UNIT_ALU, 5'd7, 1, 5'd5, 1, 5'd2, 1, 0);
    raw2  = mk(1, UNIT_ALU, 5'd7, 1, 5'd2, 1, 5'd5, 1, 0);
    mem   = mk(1, UNIT_MEM, 5'd8, 1, 5'd1, 1, 5'd0, 0, 0);
    mdv   = mk(1, UNIT_MULDIV, 5'd10, 1, 5'd3, 1, 5'd4, 1, 0);
    csr   = mk(1, UNIT_ALU, 5'd11, 1, 5'd1, 1, 5'd0, 0, 1);
    nil   = mk(0, UNIT_ALU, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    waw0  = mk(1, UNIT_ALU, 5'd9, 1, 5'd1, 1, 5'd2, 1, 0);
    waw1  = mk(1, UNIT_ALU, 5'd9, 1, 5'd3, 1, 5'd4, 1, 0);

    add(alu_a, alu_b, 2'b11, 2'b11, "dual");
    add(alu_a, raw1, 2'b11, 2'b01, "raw_rs1");
    add(alu_a, raw2, 2'b11, 2'b01, "raw_rs2");
    add(alu_a, mk(1, UNIT_ALU, 5'd7, 1, 5'd2, 1, 5'd5, 0, 0), 2'b11, 2'b11, "raw_unused_rs2");
    add(mk(1, UNIT_ALU, 5'd0, 1, 5'd1, 1, 5'd2, 1, 0),
        mk(1, UNIT_ALU, 5'd7, 1, 5'd0, 1, 5'd2, 1, 0), 2'b11, 2'b11, "x0_rd");
    add(waw0, waw1, 2'b11, 2'b01, "waw");
    add(mk(1, UNIT_ALU, 5'd9, 0, 5'd1, 1, 5'd2, 1, 0), waw1, 2'b11, 2'b11, "waw_no_we0");
    add(mem, mem, 2'b11, 2'b01, "mem_mem");
    add(mem, mem, 2'b10, 2'b00, "mem_mem_r10");
    add(mdv, mdv, 2'b11, 2'b01, "muldiv_muldiv");
    add(mem, mdv, 2'b11, 2'b11, "mem_muldiv");
    add(nil, alu_b, 2'b11, 2'b00, "slot0_empty");
    add(alu_a, alu_b, 2'b01, 2'b01, "ready01");
    add(alu_a, mk(1, UNIT_ALU, 5'd6, 1, 5'd3, 1, 5'd4, 1, 1), 2'b11, 2'b01, "serial_slot1");
    add(alu_a, nil, 2'b11, 2'b01, "slot1_empty");
    add(alu_a, alu_b, 2'b10, 2'b00, "ready10");

    rstn = 1'b0; flush = 1'b0; drain_done = 1'b0; clear_cnt = 1'b0;
    drive(alu_a, alu_b, 2'b11);
    #1;
    chk("reset read_head", 32'(read_head), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cnt_dual", 32'(cnt_dual), 32'd0);
    chk("reset cnt_single", 32'(cnt_single), 32'd0);
    chk("reset cnt_stall", 32'(cnt_stall), 32'd0);
    rstn = 1'b1;

    foreach (vecs[i]) step(vecs[i].s0, vecs[i].s1, vecs[i].ready, 0, 0, 0, vecs[i].exp_rh, 0, vecs[i].name);

    step(alu_a, alu_b, 2'b11, 1, 0, 0, 2'b11, 0, "drain_in_run");

    // Serializing instruction, five wait cycles, drain, then resume.
    step(csr, alu_b, 2'b11, 0, 0, 0, 2'b01, 1, "csr_issue");
    for (int i = 0; i < 5; i++) step(alu_a, alu_b, 2'b11, 0, 0, 0, 2'b00, 1, "serial_wait");
    step(alu_a, alu_b, 2'b11, 1, 0, 0, 2'b00, 0, "drain_done");
    step(alu_a, alu_b, 2'b11, 0, 0, 0, 2'b11, 0, "after_drain");

    // Flush inside the wait and in RUN.
    step(csr, alu_b, 2'b11, 0, 0, 0, 2'b01, 1, "csr_issue2");
    step(alu_a, alu_b, 2'b11, 0, 1, 0, 2'b00, 0, "flush_wait");
    step(alu_a, alu_b, 2'b11, 0, 1, 0, 2'b00, 0, "flush_run");
    step(csr, alu_b, 2'b11, 0, 1, 0, 2'b00, 0, "flush_over_csr");
    step(alu_a, alu_b, 2'b11, 0, 0, 0, 2'b11, 0, "after_flush");

    // Reset for one cycle in the middle of a wait.
    step(csr, alu_b, 2'b11, 0, 0, 0, 2'b01, 1, "csr_issue3");
    rstn = 1'b0;
    drive(alu_a, alu_b, 2'b11);
    #1;
    chk("midreset read_head", 32'(read_head), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    e_dual = '0; e_single = '0; e_stall = '0;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset cnt_dual", 32'(cnt_dual), 32'd0);
    chk("midreset cnt_single", 32'(cnt_single), 32'd0);
    chk("midreset cnt_stall", 32'(cnt_stall), 32'd0);
    step(alu_a, alu_b, 2'b11, 0, 0, 0, 2'b11, 0, "after_reset");

    // Clear beats a coincident dual issue.
    step(alu_a, raw1, 2'b11, 0, 0, 0, 2'b01, 0, "pre_clear_single");
    step(alu_a, alu_b, 2'b10, 0, 0, 0, 2'b00, 0, "pre_clear_stall");
    step(alu_a, alu_b, 2'b11, 0, 0, 1, 2'b11, 0, "clear_dual");

    // Wrap: drive cnt_dual to all-ones, then one more dual issue returns it to zero.
    for (int i = 0; i < (1 << CW) - 1; i++) step(alu_a, alu_b, 2'b11, 0, 0, 0, 2'b11, 0, "fill_dual");
    chk("dual_at_max", 32'(cnt_dual), 32'((1 << CW) - 1));
    step(alu_a, alu_b, 2'b11, 0, 0, 0, 2'b11, 0, "dual_wrap");
    chk("dual_wrapped", 32'(cnt_dual), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
